// File: rtl/gpio_uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_uart_tx_if
//  Description : Processor GPIO byte-write port. The processor drives a byte
//                on GPIO and qualifies it with GPIOEn for exactly one clock
//                per byte written.
//                  GPIO   [7:0]  byte written by the processor
//                  GPIOEn        write strobe (one byte per strobed edge)
//                master = processor side, slave = peripheral side.
//  Revision    : 1.0  initial release
// ============================================================================
interface gpio_uart_tx_if;
    logic [7:0] GPIO;
    logic       GPIOEn;

    modport master (output GPIO, output GPIOEn);
    modport slave  (input  GPIO, input  GPIOEn);
endinterface
`default_nettype wire

// File: rtl/gpio_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_uart_tx
//  Description : Serial console on the processor GPIO byte-write port. Every
//                strobed byte is queued in a small FIFO and transmitted as an
//                8N1 UART frame, LSB first. There is no back-pressure: a
//                write arriving while the FIFO is full is dropped and
//                recorded in a sticky overflow flag.
//  Ports       : clk      system clock
//                rst      synchronous active-high reset
//                bus      GPIO write port (slave modport: GPIO, GPIOEn)
//                tx       UART line, idle high, registered
//                busy     a frame is in progress
//                full     FIFO holds FIFO_DEPTH bytes
//                count    bytes queued, excluding the byte being shifted
//                overflow sticky, at least one write was dropped
//  Revision    : 1.0  initial release
// ============================================================================
module gpio_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  wire                          clk,
    input  wire                          rst,
    gpio_uart_tx_if.slave                bus,
    output logic                         tx,
    output logic                         busy,
    output logic                         full,
    output logic [$clog2(FIFO_DEPTH):0]  count,
    output logic                         overflow
);

    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [c_BAUD_W-1:0] c_BAUD_RELOAD = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_PTR_W:0]    c_DEPTH       = (c_PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wptr;
    logic [c_PTR_W-1:0]  r_rptr;
    logic [c_PTR_W:0]    r_count;
    logic                r_overflow;

    logic [1:0]          r_state;
    logic [7:0]          r_shift;
    logic [2:0]          r_bit_idx;
    logic [c_BAUD_W-1:0] r_baud;
    logic                r_tx;

    logic w_empty;
    logic w_full;
    logic w_baud_done;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_DEPTH);
    assign w_baud_done = (r_baud == '0);

    // A pop happens when a new frame can start: from IDLE, or at the very
    // edge that ends a stop bit, so consecutive frames are gapless.
    assign w_pop  = !w_empty &&
                    ((r_state == c_IDLE) || ((r_state == c_STOP) && w_baud_done));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push = bus.GPIOEn && (!w_full || w_pop);
    assign w_drop = bus.GPIOEn && !w_push;

    // Storage carries no reset; validity is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.GPIO;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // r_tx is loaded with the level of the bit being entered, so the line is
    // a registered decode of state and shift register only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_baud    <= '0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_pop) begin
                        r_state <= c_START;
                        r_shift <= r_mem[r_rptr];
                        r_baud  <= c_BAUD_RELOAD;
                        r_tx    <= 1'b0;
                    end
                end
                c_START: begin
                    if (w_baud_done) begin
                        r_state   <= c_DATA;
                        r_bit_idx <= '0;
                        r_baud    <= c_BAUD_RELOAD;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                c_DATA: begin
                    if (w_baud_done) begin
                        r_baud <= c_BAUD_RELOAD;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= c_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                c_STOP: begin
                    if (w_baud_done) begin
                        if (w_pop) begin
                            r_state <= c_START;
                            r_shift <= r_mem[r_rptr];
                            r_baud  <= c_BAUD_RELOAD;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= c_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign tx       = r_tx;
    assign busy     = (r_state != c_IDLE);
    assign full     = w_full;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_gpio_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpio_uart_tx
//  Description : Directed self-checking bench for gpio_uart_tx with
//                CLKS_PER_BIT=4 and FIFO_DEPTH=4. A UART receiver process
//                decodes the line and compares each byte with the queue of
//                bytes the stimulus expects on the wire.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gpio_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx;
    logic       busy;
    logic       full;
    logic [2:0] count;
    logic       overflow;

    gpio_uart_tx_if bus ();

    gpio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .tx       (tx),
        .busy     (busy),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int         checks    = 0;
    int         errors    = 0;
    logic [7:0] exp_q[$];
    int         exp_total = 0;
    int         rx_count  = 0;
    int         rst_epoch = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled at the falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic put(input logic [7:0] b, input bit expect_on_line);
        bus.GPIO   = b;
        bus.GPIOEn = 1'b1;
        if (expect_on_line) begin
            exp_q.push_back(b);
            exp_total++;
        end
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            cyc();
            if (!busy && count == 3'd0) begin
                done = 1'b1;
                break;
            end
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    // UART receiver: hunts for a start bit, samples mid-bit.
    initial begin : g_monitor
        int         ep;
        logic [7:0] d;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx === 1'b0) begin
                ep = rst_epoch;
                repeat (2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    d[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                if (ep == rst_epoch) begin
                    rx_count++;
                    check("rx_stop_bit", {31'd0, tx}, 32'd1);
                    if (exp_q.size() == 0) begin
                        check("rx_extra_byte", {24'd0, d}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_byte", {24'd0, d}, {24'd0, e});
                    end
                end
            end
        end
    end

    initial begin : g_stim
        logic [9:0] frame;
        bit         quiet;

        rst        = 1'b1;
        bus.GPIO   = 8'h00;
        bus.GPIOEn = 1'b0;
        cyc();
        check("reset_tx",       {31'd0, tx},       32'd1);
        check("reset_busy",     {31'd0, busy},     32'd0);
        check("reset_full",     {31'd0, full},     32'd0);
        check("reset_count",    {29'd0, count},    32'd0);
        check("reset_overflow", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        cyc();

        // Single byte A5: exact line waveform and latency.
        put(8'hA5, 1'b1);
        cyc();
        bus.GPIOEn = 1'b0;
        check("t1_count_after_write", {29'd0, count}, 32'd1);
        check("t1_tx_still_idle",     {31'd0, tx},    32'd1);
        check("t1_busy_before_pop",   {31'd0, busy},  32'd0);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 10 * CPB; i++) begin
            cyc();
            check("t1_tx_bit", {31'd0, tx}, {31'd0, frame[i / CPB]});
            if (i == 0) begin
                check("t1_busy_at_start", {31'd0, busy},  32'd1);
                check("t1_count_popped",  {29'd0, count}, 32'd0);
            end
        end
        cyc();
        check("t1_busy_end", {31'd0, busy}, 32'd0);
        check("t1_tx_end",   {31'd0, tx},   32'd1);

        // Back-to-back 00, FF: gapless frames.
        put(8'h00, 1'b1);
        cyc();
        check("t2_count_1", {29'd0, count}, 32'd1);
        put(8'hFF, 1'b1);
        cyc();
        bus.GPIOEn = 1'b0;
        check("t2_count_2",     {29'd0, count}, 32'd1);
        check("t2_first_start", {31'd0, tx},    32'd0);
        repeat (39) cyc();
        check("t2_last_stop_cycle", {31'd0, tx},    32'd1);
        check("t2_count_3",         {29'd0, count}, 32'd1);
        cyc();
        check("t2_second_start", {31'd0, tx},    32'd0);
        check("t2_busy_between", {31'd0, busy},  32'd1);
        check("t2_count_4",      {29'd0, count}, 32'd0);
        wait_idle("t2_drain_timeout");

        // Fill and overflow: 01..06, 06 dropped.
        for (int b = 1; b <= 6; b++) begin
            put(8'(b), b <= 5);
            cyc();
            if (b == 5) begin
                check("t3_full",         {31'd0, full},     32'd1);
                check("t3_count_full",   {29'd0, count},    32'd4);
                check("t3_no_overflow",  {31'd0, overflow}, 32'd0);
            end
        end
        bus.GPIOEn = 1'b0;
        check("t3_overflow_set", {31'd0, overflow}, 32'd1);
        check("t3_count_kept",   {29'd0, count},    32'd4);
        wait_idle("t3_drain_timeout");
        check("t3_overflow_sticky", {31'd0, overflow}, 32'd1);

        // Reset during DATA bit 3 with two bytes queued.
        put(8'h11, 1'b0);
        cyc();
        put(8'h22, 1'b0);
        cyc();
        put(8'h33, 1'b0);
        cyc();
        bus.GPIOEn = 1'b0;
        check("t5_count_queued", {29'd0, count}, 32'd2);
        repeat (15) cyc();
        check("t5_busy_mid_frame", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        rst_epoch++;
        cyc();
        rst = 1'b0;
        check("t5_tx",       {31'd0, tx},       32'd1);
        check("t5_busy",     {31'd0, busy},     32'd0);
        check("t5_count",    {29'd0, count},    32'd0);
        check("t5_overflow", {31'd0, overflow}, 32'd0);
        check("t5_full",     {31'd0, full},     32'd0);
        quiet = 1'b1;
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
        end
        check("t5_line_quiet", {31'd0, quiet}, 32'd1);

        // Push while full, accepted on the edge that ends STOP.
        for (int b = 1; b <= 5; b++) begin
            put(8'(b), 1'b1);
            cyc();
        end
        bus.GPIOEn = 1'b0;
        check("t4_full_before", {31'd0, full}, 32'd1);
        repeat (36) cyc();
        check("t4_count_before", {29'd0, count}, 32'd4);
        put(8'h07, 1'b1);
        cyc();
        bus.GPIOEn = 1'b0;
        check("t4_count_after",   {29'd0, count},    32'd4);
        check("t4_overflow_zero", {31'd0, overflow}, 32'd0);
        check("t4_full_after",    {31'd0, full},     32'd1);
        check("t4_next_start",    {31'd0, tx},       32'd0);
        wait_idle("t4_drain_timeout");

        // Pointer wrap-around: 3*DEPTH bytes in bursts the line can drain.
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 3; j++) begin
                put(8'h40 + 8'(r * 3 + j), 1'b1);
                cyc();
            end
            bus.GPIOEn = 1'b0;
            wait_idle("t6_drain_timeout");
        end
        check("t6_overflow_zero", {31'd0, overflow}, 32'd0);

        repeat (4) cyc();
        check("rx_all_received", rx_count,                exp_total);
        check("rx_queue_empty",  32'(exp_q.size()),       32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gpio_uart_tx.md
# gpio_uart_tx

Serial console peripheral that sits on the processor's GPIO byte-write port (`GPIO[7:0]` qualified by `GPIOEn`) and transmits each written byte as an 8N1 UART frame. Bytes are buffered in a small FIFO, because the processor pipeline has no stall path back from the memory controller. This block is the consumer end of the GPIO write interface. Overflow is reported with a sticky flag rather than back-pressure.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200). Legal values are ≥ 2.
- `FIFO_DEPTH`, 16: byte FIFO depth. Must be a power of two, ≥ 2.
- `clk`  input  1  system clock, same domain as the processor.
- `rst`  input  1  synchronous, active-high reset.
- `GPIO`  input  8  byte written by the processor.
- `GPIOEn`  input  1  write strobe. Each rising edge of `clk` with `GPIOEn`=1 is exactly one byte write.
- `tx`  output  1  UART serial line, idle high.
- `busy`  output  1  a frame is in progress (FSM not in IDLE).
- `full`  output  1  FIFO holds `FIFO_DEPTH` bytes.
- `count`  output  $clog2(FIFO_DEPTH)+1  number of bytes queued, excluding the byte being shifted.
- `overflow`  output  1  sticky: at least one write was dropped. Cleared only by `rst`.

## Operation
- FIFO:
  - Circular buffer with read and write pointers of width $clog2(FIFO_DEPTH); pointers wrap modulo `FIFO_DEPTH`.
  - `count` is maintained separately.
  - Push when `GPIOEn`=1 and (`full`=0 or a pop occurs in the same cycle).
  - Otherwise a write with `full`=1 is dropped and `overflow` is set.
- FSM states:
  - IDLE → START: when the FIFO is non-empty. Pop the head byte into an 8-bit shift register and load the baud counter with `CLKS_PER_BIT`-1.
  - START: drive `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: drive `tx`=shift[0] (LSB first). Each time the baud counter reaches 0, shift right and increment the bit index. After bit 7 completes, go to STOP.
  - STOP: drive `tx`=1 for `CLKS_PER_BIT` cycles. When it completes:
    - FIFO non-empty: pop in that same cycle and go directly to START. No idle gap is inserted between frames.
    - FIFO empty: go to IDLE.
- Baud counter: counts down from `CLKS_PER_BIT`-1 to 0. It is reloaded at every bit boundary.
- `tx` is registered and is a decode of the state and shift register only. It never glitches from `GPIO`.
- Simultaneous push into an empty FIFO while the FSM is in IDLE: the byte is written this cycle and popped next cycle. There is no bypass path.
- Simultaneous push and pop while `full`=1: the write is accepted, `count` is unchanged, and `overflow` is not set.

## Timing
- Reset values: `tx`=1, `busy`=0, `full`=0, `count`=0, `overflow`=0. FIFO pointers are 0 and the FSM is in IDLE.
- Reset mid-frame: at the next edge `tx` returns to 1, queued bytes are discarded, and `overflow` clears. No partial frame resumes.
- Write-to-line latency, with the FSM idle and the FIFO empty:
  - Write sampled at edge k.
  - `count`=1 after edge k.
  - Pop and START entry at edge k+1: `tx`=0, `busy`=1, `count`=0 after edge k+1.
- Frame length: exactly 10×`CLKS_PER_BIT` cycles from the first cycle of `tx`=0 to the end of the stop bit.
- `busy` falls at the edge that ends STOP when the FIFO is empty.
- `full` and `count` update at the same edge as the push or pop.
- `overflow` sets at the edge that samples the dropped write.

## Test plan
- Single byte, `CLKS_PER_BIT`=4: write 8'hA5 → one cycle later `tx` holds each of 0,1,0,1,0,0,1,0,1,1 for 4 cycles (40 cycles total), then `busy`=0 and `tx`=1.
- Back-to-back bytes: write 8'h00 then 8'hFF on consecutive cycles → two frames with no idle cycle between the first stop bit and the second start bit; `count` goes 1, 1, 0.
- Fill and overflow, `FIFO_DEPTH`=4: write 6 bytes (8'h01..8'h06) on consecutive cycles →
  - 8'h01 is popped and 8'h02..8'h05 fill the FIFO.
  - `full`=1; 8'h06 is dropped and `overflow`=1.
  - The transmitted sequence is 01, 02, 03, 04, 05.
- Push while full with a simultaneous pop: with the FIFO full, write on the cycle STOP ends → the byte is accepted, `count` stays 4, and `overflow` stays 0.
- Reset mid-frame: assert `rst` during DATA bit 3 with 2 bytes queued → after one edge `tx`=1, `busy`=0, `count`=0, `overflow`=0, and there is no further line activity.
- Wrap-around: stream 3×`FIFO_DEPTH` bytes at a rate the line can drain, so there are no drops → all bytes are received in order by a bench UART monitor, and `overflow` stays 0.
